// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronises and filters the raw lines, deframes bytes,
// and folds E0/F0/E1 prefixes into toggle-style 11-bit key events.
module ps2_key_decoder #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 16384
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        err,
    output logic        busy
);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic          r_filt_clk, r_filt_clk_d;
    logic [7:0]    r_filt_cnt;
    logic          w_fe;

    state_t        r_state;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_parity;
    logic [TW-1:0] r_to_cnt;
    logic          r_rx_stb;
    logic [7:0]    r_rx_byte;
    logic          r_ext, r_rel;
    logic [2:0]    r_pause;
    logic [10:0]   r_key;
    logic          r_err;
    logic          w_frame_ok, w_timeout, w_ignore;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_s1     <= 1'b1;
            r_clk_s2     <= 1'b1;
            r_dat_s1     <= 1'b1;
            r_dat_s2     <= 1'b1;
            r_filt_clk   <= 1'b1;
            r_filt_clk_d <= 1'b1;
            r_filt_cnt   <= '0;
        end else begin
            r_clk_s1     <= ps2_clk;
            r_clk_s2     <= r_clk_s1;
            r_dat_s1     <= ps2_data;
            r_dat_s2     <= r_dat_s1;
            r_filt_clk_d <= r_filt_clk;
            // Level flips on the FILTER_LEN-th consecutive differing sample
            if (r_clk_s2 == r_filt_clk) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == 8'(FILTER_LEN - 1)) begin
                r_filt_clk <= r_clk_s2;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 8'd1;
            end
        end
    end

    assign w_fe       = r_filt_clk_d & ~r_filt_clk;
    assign w_frame_ok = (^r_shift ^ r_parity) & r_dat_s2;
    assign w_timeout  = (r_state != S_IDLE) && (r_to_cnt == TW'(TIMEOUT - 1)) && !w_fe;
    assign w_ignore   = (r_rx_byte == 8'h00) || (r_rx_byte == 8'hAA) || (r_rx_byte == 8'hEE) ||
                        (r_rx_byte == 8'hFA) || (r_rx_byte == 8'hFE) || (r_rx_byte == 8'hFF);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_to_cnt  <= '0;
            r_rx_stb  <= 1'b0;
            r_rx_byte <= '0;
            r_ext     <= 1'b0;
            r_rel     <= 1'b0;
            r_pause   <= '0;
            r_key     <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err    <= 1'b0;
            r_rx_stb <= 1'b0;

            if (r_state == S_IDLE || w_fe || w_timeout)
                r_to_cnt <= '0;
            else
                r_to_cnt <= r_to_cnt + TW'(1);

            if (w_fe) begin
                case (r_state)
                    S_IDLE: begin
                        if (!r_dat_s2) begin
                            r_state   <= S_DATA;
                            r_bit_cnt <= '0;
                        end
                    end
                    S_DATA: begin
                        r_shift[r_bit_cnt] <= r_dat_s2;
                        if (r_bit_cnt == 3'd7)
                            r_state <= S_PARITY;
                        else
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    S_PARITY: begin
                        r_parity <= r_dat_s2;
                        r_state  <= S_STOP;
                    end
                    S_STOP: begin
                        r_state <= S_IDLE;
                        if (w_frame_ok) begin
                            r_rx_stb  <= 1'b1;
                            r_rx_byte <= r_shift;
                        end else begin
                            r_err   <= 1'b1;
                            r_ext   <= 1'b0;
                            r_rel   <= 1'b0;
                            r_pause <= '0;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end else if (w_timeout) begin
                r_state <= S_IDLE;
                r_err   <= 1'b1;
                r_ext   <= 1'b0;
                r_rel   <= 1'b0;
            end

            // Byte interpretation runs one clk after the stop-bit edge
            if (r_rx_stb) begin
                if (r_pause != '0) begin
                    r_pause <= r_pause - 3'd1;
                end else if (r_rx_byte == 8'hE0) begin
                    r_ext <= 1'b1;
                end else if (r_rx_byte == 8'hF0) begin
                    r_rel <= 1'b1;
                end else if (r_rx_byte == 8'hE1) begin
                    r_pause <= 3'd7;
                end else if (!(w_ignore && !r_ext && !r_rel)) begin
                    r_key <= {~r_key[10], ~r_rel, r_ext, r_rx_byte};
                    r_ext <= 1'b0;
                    r_rel <= 1'b0;
                end
            end
        end
    end

    assign ps2_key = r_key;
    assign err     = r_err;
    assign busy    = (r_state != S_IDLE);
endmodule
